// File: rtl/pipe_reg_nbit.sv
// -----------------------------------------------------------------------------
// pipe_reg_nbit
//
// Parametrised multi-stage register pipeline with per-stage valid tracking,
// clock enable (stall) and synchronous flush. It retimes bus address/data/
// control bundles across clock-edge boundaries so that flip-flops do not have
// to be chained by hand.
//
// Each stage holds {valid, data}. When the pipe advances, data and valid shift
// together unconditionally. A bubble (valid = 0) carries its data field along
// with it, so Q always shows the last stage's data, whether or not it is valid.
//
// Parameters
//   busWidth     data bits per stage (>= 1)
//   DEPTH        number of register stages (>= 1, 0 is rejected at elaboration)
//   RESET_VALUE  data value loaded into every stage on reset and on flush
//
// Ports
//   clk        in   1                rising-edge system clock
//   reset_n    in   1                asynchronous active-low reset
//   en         in   1                advance enable, 0 = every stage holds
//   flush      in   1                synchronous clear of all stages (beats en)
//   D          in   busWidth         input data
//   D_valid    in   1                input data qualifier
//   Q          out  busWidth         data of the last stage
//   Q_valid    out  1                valid of the last stage
//   occupancy  out  clog2(DEPTH+1)   number of stages holding valid data
//
// Build option
//   PIPE_OCCUPANCY_EN  when defined, the occupancy port and its counter are
//                      present. When undefined, both are absent and all other
//                      behaviour is the same.
//
// Priority at each rising edge: reset_n low > flush > en > hold.
// -----------------------------------------------------------------------------
module pipe_reg_nbit #(
    parameter int unsigned          busWidth    = 8,
    parameter int unsigned          DEPTH       = 2,
    parameter logic [busWidth-1:0]  RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    flush,
    input  logic [busWidth-1:0]     D,
    input  logic                    D_valid,
    output logic [busWidth-1:0]     Q,
    output logic                    Q_valid
`ifdef PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    // A zero-depth pipe has no last stage to drive Q from.
    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_reg_nbit: DEPTH must be at least 1");
    end

    // -------------------------------------------------------------------------
    // Stage storage. Index 0 is the entry stage, index DEPTH-1 drives Q.
    // -------------------------------------------------------------------------
    logic [busWidth-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0]    stage_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= RESET_VALUE;
            end
            stage_valid <= '0;
        end else if (flush) begin
            // Flush discards whatever is on D this cycle as well.
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i] <= RESET_VALUE;
            end
            stage_valid <= '0;
        end else if (en) begin
            stage_data[0]  <= D;
            stage_valid[0] <= D_valid;
            // When DEPTH = 1 this loop is empty and the block is a single
            // enabled register with valid.
            for (int i = 1; i < DEPTH; i++) begin
                stage_data[i]  <= stage_data[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Outputs come straight from the last stage flops; no input reaches them
    // combinationally.
    assign Q       = stage_data[DEPTH-1];
    assign Q_valid = stage_valid[DEPTH-1];

`ifdef PIPE_OCCUPANCY_EN
    // -------------------------------------------------------------------------
    // Occupancy counter. It tracks the popcount of stage_valid by adding what
    // enters and subtracting what leaves on each advance. The counter stays
    // in 0..DEPTH by construction: it can only increment when the last stage
    // is empty, so at least one stage is free.
    // -------------------------------------------------------------------------
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_next;

    always_comb begin
        occ_next = occ_q;
        if (D_valid && !stage_valid[DEPTH-1]) begin
            occ_next = occ_q + OCC_W'(1);
        end else if (!D_valid && stage_valid[DEPTH-1]) begin
            occ_next = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (en) begin
            occ_q <= occ_next;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule
